mul_div_unit: RTL

//  Iterative multiply/divide unit for the execute stage; runs beside the ALU on the same A/B operands.

---
 rtl/mul_div_unit_pkg.sv | 26 ++
 rtl/mul_div_unit_if.sv | 19 +
 rtl/md_iter_step.sv | 37 +++
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared op codes and widths for the iterative multiply/divide unit.
// The decoder emits md_op_e next to the ALU op codes.
package mul_div_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_OP_W  = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Execute-stage issue/result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
);
  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, flush, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring shift-subtract divide step
// on unsigned magnitudes. Purely combinational; the parent owns all state.
module md_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] opr_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] opr_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum     = opr_i[0] ? (acc_i + {1'b0, operand_i}) : acc_i;
    shifted = {acc_i[WIDTH-1:0], opr_i[WIDTH-1]};
    // Extra top bit makes the trial-subtract borrow visible even when shifted >= 2^WIDTH.
    diff    = {1'b0, shifted} - {2'b00, operand_i};
    if (div_mode) begin
      if (!diff[WIDTH+1]) begin
        acc_o = diff[WIDTH:0];
        opr_o = {opr_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted;
        opr_o = {opr_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, sum[WIDTH:1]};
      opr_o = {sum[0], opr_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding architectural HI/LO.
// Mult/div take WIDTH+1 busy cycles; MTHI/MTLO complete at the issue edge.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave md
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]     step_acc;
  logic [WIDTH-1:0]   step_opr;
  logic               a_neg, b_neg, op_signed;
  logic [WIDTH:0]     a_ext, b_ext;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .div_mode  (is_div_q),
    .acc_i     (acc_q),
    .opr_i     (opr_q),
    .operand_i (dvs_q),
    .acc_o     (step_acc),
    .opr_o     (step_opr)
  );

  // Operand magnitudes; the WIDTH+1 intermediate keeps |-2^(WIDTH-1)| exact.
  always_comb begin
    op_signed = md_is_signed(md.op);
    a_neg     = op_signed & md.A[WIDTH-1];
    b_neg     = op_signed & md.B[WIDTH-1];
    a_ext     = {a_neg, md.A};
    b_ext     = {b_neg, md.B};
    a_mag     = a_neg ? WIDTH'(-a_ext) : md.A;
    b_mag     = b_neg ? WIDTH'(-b_ext) : md.B;
  end

  // Sign fix-up of the finished magnitude result.
  always_comb begin
    prod_mag = {acc_q[WIDTH-1:0], opr_q};
    prod_fix = neg_lo_q ? (2*WIDTH)'(-prod_mag) : prod_mag;
    if (is_div_q) begin
      fix_lo = neg_lo_q ? WIDTH'(-opr_q) : opr_q;
      fix_hi = neg_hi_q ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (md.start) begin
          unique case (md.op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d = md_is_div(md.op);
              cnt_d    = '0;
              acc_d    = '0;
              opr_d    = md_is_div(md.op) ? a_mag : b_mag;
              dvs_d    = md_is_div(md.op) ? b_mag : a_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = md_is_div(md.op) ? a_neg : (a_neg ^ b_neg);
              div0_d   = md_is_div(md.op) && (md.B == '0);
              state_d  = (md_is_div(md.op) && (md.B == '0)) ? S_FIX : S_CALC;
            end
            MD_MTHI: hi_d = md.A;
            MD_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        opr_d = step_opr;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!div0_q) begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Squash wins over everything, including a same-cycle MTHI/MTLO.
    if (md.flush) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opr_q    <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      dvs_q    <= dvs_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule
